gameport_adc: RTL and testbench

- Emulates the PC game port at I/O 0x201 for the ISA sound card top level.
- Continuously scans a 4-channel 12-bit SPI ADC (MCP3204 protocol) on the JOY_* pins and keeps the latest code per axis.
- An I/O write fires four axis one-shots, each with a duration derived from its stored code.
- An I/O read returns the one-shot busy bits plus the synchronized buttons. Sits beside the sound/mpu blocks and consumes the joy_cs decode and the bus strobes.

---
 rtl/gameport_adc.sv | 146 ++++++++++++++
 tb/tb_gameport_adc.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gameport_adc.sv
// PC game port (0x201) emulation: scans a 4-channel MCP3204-style SPI ADC and
// converts the latest per-axis codes into the classic one-shot busy bits.
module gameport_adc #(
    parameter int US_DIV  = 50,
    parameter int SPI_DIV = 25,
    parameter int BASE_US = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs,
    input  logic        write,
    output logic [7:0]  readdata,
    output logic        joy_clk,
    output logic        joy_cs_n,
    output logic        joy_din,
    input  logic        joy_dout,
    input  logic [3:0]  joy_b,
    output logic [47:0] axis_data
);

    localparam int US_W  = (US_DIV > 1) ? $clog2(US_DIV) : 1;
    localparam int SPI_W = $clog2(2 * SPI_DIV);

    typedef enum logic {GAP, SHIFT} spi_state_t;

    spi_state_t       state_reg;
    logic [SPI_W-1:0] div_reg;
    logic [4:0]       bit_reg;
    logic [1:0]       ch_reg;
    logic [23:0]      tx_reg;
    logic [11:0]      rx_reg;
    logic [11:0]      axis_reg [4];
    logic [23:0]      cmd_word;

    logic [3:0]       sync1_reg;
    logic [3:0]       sync2_reg;
    logic [3:0]       busy_reg;
    logic [10:0]      timer_reg [4];
    logic [US_W-1:0]  us_reg;

    // Start bit, single-ended mode, D2=0, then channel select D1:D0.
    assign cmd_word = {8'b0000_0110, ch_reg, 14'b0};
    assign readdata = {sync2_reg, busy_reg};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_axis
            assign axis_data[gi*12 +: 12] = axis_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= GAP;
            div_reg   <= '0;
            bit_reg   <= '0;
            ch_reg    <= '0;
            tx_reg    <= '0;
            rx_reg    <= '0;
            joy_clk   <= 1'b0;
            joy_cs_n  <= 1'b1;
            joy_din   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                axis_reg[i] <= 12'h800;
            end
        end else begin
            case (state_reg)
                GAP: begin
                    if (div_reg == SPI_W'(2 * SPI_DIV - 1)) begin
                        state_reg <= SHIFT;
                        div_reg   <= '0;
                        bit_reg   <= '0;
                        joy_cs_n  <= 1'b0;
                        joy_din   <= cmd_word[23];
                        tx_reg    <= {cmd_word[22:0], 1'b0};
                    end else begin
                        div_reg <= div_reg + SPI_W'(1);
                    end
                end
                SHIFT: begin
                    if (div_reg == SPI_W'(SPI_DIV - 1)) begin
                        div_reg <= '0;
                        if (!joy_clk) begin
                            joy_clk <= 1'b1;
                            rx_reg  <= {rx_reg[10:0], joy_dout};
                        end else begin
                            joy_clk <= 1'b0;
                            if (bit_reg == 5'd23) begin
                                joy_cs_n         <= 1'b1;
                                axis_reg[ch_reg] <= rx_reg;
                                ch_reg           <= ch_reg + 2'd1;
                                state_reg        <= GAP;
                            end else begin
                                bit_reg <= bit_reg + 5'd1;
                                joy_din <= tx_reg[23];
                                tx_reg  <= {tx_reg[22:0], 1'b0};
                            end
                        end
                    end else begin
                        div_reg <= div_reg + SPI_W'(1);
                    end
                end
                default: state_reg <= GAP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 4'hF;
            sync2_reg <= 4'hF;
        end else begin
            sync1_reg <= joy_b;
            sync2_reg <= sync1_reg;
        end
    end

    // A write always wins over a same-cycle tick, so a retrigger restarts cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= '0;
            us_reg   <= '0;
            for (int i = 0; i < 4; i++) begin
                timer_reg[i] <= '0;
            end
        end else if (cs && write) begin
            busy_reg <= 4'hF;
            us_reg   <= '0;
            for (int i = 0; i < 4; i++) begin
                timer_reg[i] <= 11'(BASE_US) + {1'b0, axis_reg[i][11:2]};
            end
        end else if (us_reg == US_W'(US_DIV - 1)) begin
            us_reg <= '0;
            for (int i = 0; i < 4; i++) begin
                if (timer_reg[i] != 11'd0) begin
                    timer_reg[i] <= timer_reg[i] - 11'd1;
                    if (timer_reg[i] == 11'd1) begin
                        busy_reg[i] <= 1'b0;
                    end
                end
            end
        end else begin
            us_reg <= us_reg + US_W'(1);
        end
    end

endmodule

// File: tb/tb_gameport_adc.sv
// Randomized scoreboard bench for gameport_adc: an ADC model serves codes over SPI,
// expected frames, busy edges and button changes are queued and checked by a monitor.
module tb_gameport_adc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cs = 1'b0;
    logic        write = 1'b0;
    logic        joy_dout = 1'b0;
    logic [3:0]  joy_b = 4'hF;
    logic [7:0]  readdata;
    logic        joy_clk;
    logic        joy_cs_n;
    logic        joy_din;
    logic [47:0] axis_data;

    gameport_adc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs        (cs),
        .write     (write),
        .readdata  (readdata),
        .joy_clk   (joy_clk),
        .joy_cs_n  (joy_cs_n),
        .joy_din   (joy_din),
        .joy_dout  (joy_dout),
        .joy_b     (joy_b),
        .axis_data (axis_data)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        total++;
        $display("FAIL %s: actual=missing expected=event", name);
    endtask

    // ---------------- reference data and scoreboard queues ----------------
    typedef struct {logic [23:0] mosi; logic [1:0] ch;} frame_t;
    typedef struct {int ch; int cyc; logic rise;} busy_ev_t;
    typedef struct {int cyc; logic [3:0] val;} btn_ev_t;

    logic [11:0] adc_val [4];
    logic [11:0] exp_axis [4];
    frame_t      frame_q[$];
    busy_ev_t    ev_q[$];
    btn_ev_t     btn_q[$];
    int          frames_seen = 0;

    // ---------------- ADC (MCP3204-like) model ----------------
    int          adc_k = 0;
    logic [23:0] adc_rx = '0;
    logic [1:0]  adc_ch = '0;
    logic [11:0] adc_code;
    logic        adc_prev_cs = 1'b1;
    logic        adc_prev_clk = 1'b0;

    always @(joy_cs_n or joy_clk) begin
        if (adc_prev_cs && !joy_cs_n) begin
            adc_k = 0;
            adc_rx = '0;
            joy_dout = 1'($urandom_range(0, 1));
        end else if (!adc_prev_clk && joy_clk) begin
            adc_rx = {adc_rx[22:0], joy_din};
            adc_k++;
        end else if (adc_prev_clk && !joy_clk && !joy_cs_n && adc_k < 24) begin
            if (adc_k < 12) begin
                joy_dout = 1'($urandom_range(0, 1));
            end else begin
                if (adc_k == 12) adc_ch = adc_rx[3:2];
                adc_code = adc_val[adc_ch];
                joy_dout = adc_code[23 - adc_k];
            end
        end
        adc_prev_cs = joy_cs_n;
        adc_prev_clk = joy_clk;
    end

    // ---------------- monitor ----------------
    logic       prev_cs_n = 1'b1;
    logic [3:0] prev_busy = '0;
    int         low_start = -1;
    int         high_start = -1;
    logic       in_rst = 1'b0;
    int         idx;
    frame_t     f;

    always @(negedge clk) begin
        if (!rst_n) begin
            if (!in_rst) begin
                frame_q.delete();
                ev_q.delete();
                btn_q.delete();
                for (int k = 0; k < 64; k++) begin
                    f.ch = 2'(k % 4);
                    f.mosi = {8'h06, f.ch, 14'b0};
                    frame_q.push_back(f);
                end
                for (int k = 0; k < 4; k++) exp_axis[k] = 12'h800;
            end
            in_rst = 1'b1;
            prev_cs_n = 1'b1;
            prev_busy = '0;
            low_start = -1;
            high_start = -1;
        end else begin
            in_rst = 1'b0;
            if (prev_cs_n && !joy_cs_n) begin
                if (high_start >= 0) check("cs_high_len", cyc - high_start, 50);
                low_start = cyc;
            end
            if (!prev_cs_n && joy_cs_n) begin
                if (low_start >= 0) check("cs_low_len", cyc - low_start, 1200);
                high_start = cyc;
                if (frame_q.size() == 0) begin
                    fail_now("frame_unexpected");
                end else begin
                    f = frame_q.pop_front();
                    check("mosi_word", adc_rx, f.mosi);
                    exp_axis[f.ch] = adc_val[f.ch];
                    check("axis_data", axis_data,
                          {exp_axis[3], exp_axis[2], exp_axis[1], exp_axis[0]});
                    frames_seen++;
                    $display("frame ch=%0d mosi=%06h axis=%012h", f.ch, adc_rx, axis_data);
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (readdata[i] != prev_busy[i]) begin
                    idx = -1;
                    for (int j = 0; j < ev_q.size(); j++) begin
                        if (idx < 0 && ev_q[j].ch == i && ev_q[j].rise == readdata[i]) idx = j;
                    end
                    if (idx < 0) begin
                        fail_now($sformatf("busy%0d_unexpected_edge", i));
                    end else begin
                        check($sformatf("busy%0d_edge_cycle", i), cyc, ev_q[idx].cyc);
                        ev_q.delete(idx);
                        $display("busy%0d -> %0b at cycle %0d readdata=%02h",
                                 i, readdata[i], cyc, readdata);
                    end
                end
            end
            if (btn_q.size() > 0 && cyc >= btn_q[0].cyc) begin
                check("buttons", readdata[7:4], btn_q[0].val);
                $display("buttons at cycle %0d readdata=%02h", cyc, readdata);
                void'(btn_q.pop_front());
            end
            prev_cs_n = joy_cs_n;
            prev_busy = readdata[3:0];
        end
    end

    // ---------------- stimulus ----------------
    logic [3:0] cur_b = 4'hF;

    // Fire a port write so that the DUT loads its timers at edge n_target (or later).
    task automatic do_write(input int n_target, output int n);
        int t;
        int found;
        busy_ev_t e;
        do @(negedge clk); while (cyc < n_target - 1);
        #1;
        n = cyc + 1;
        for (int i = 0; i < 4; i++) begin
            t = 24 + int'(exp_axis[i][11:2]);
            found = -1;
            for (int j = 0; j < ev_q.size(); j++) begin
                if (found < 0 && ev_q[j].ch == i && !ev_q[j].rise) found = j;
            end
            if (found >= 0) begin
                ev_q.delete(found);
            end else begin
                e.ch = i; e.cyc = n; e.rise = 1'b1;
                ev_q.push_back(e);
            end
            e.ch = i; e.cyc = n + t * 50; e.rise = 1'b0;
            ev_q.push_back(e);
        end
        $display("write at cycle %0d", n);
        cs = 1'b1;
        write = 1'b1;
        @(negedge clk);
        #1;
        cs = 1'b0;
        write = 1'b0;
    endtask

    task automatic set_buttons(input logic [3:0] v);
        btn_ev_t b;
        @(negedge clk);
        #1;
        b.cyc = cyc + 1; b.val = cur_b;
        btn_q.push_back(b);
        b.cyc = cyc + 2; b.val = v;
        btn_q.push_back(b);
        joy_b = v;
        cur_b = v;
        $display("buttons driven %04b at cycle %0d", v, cyc);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int base;
        int k;
        base = frames_seen;
        k = 0;
        while (frames_seen < base + n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (frames_seen < base + n) fail_now("frame_timeout");
    endtask

    initial begin
        int n1;
        int n2;
        int n3;
        int k;
        adc_val[0] = 12'h000;
        adc_val[1] = 12'h3FF;
        adc_val[2] = 12'hFFF;
        adc_val[3] = 12'h800;

        #5 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_cs_n", joy_cs_n, 1);
        check("rst_sck", joy_clk, 0);
        check("rst_mosi", joy_din, 0);
        check("rst_readdata", readdata, 8'hF0);
        check("rst_axis", axis_data, 48'h800800800800);
        rst_n = 1'b1;

        wait_frames(5, 7000);

        do_write(cyc + 2, n1);
        repeat (200) @(negedge clk);
        set_buttons(4'b1101);
        repeat (10) @(negedge clk);
        set_buttons(4'b1111);
        do_write(n1 + 5000, n2);
        check("rewrite_spacing", n2 - n1, 5000);

        k = 0;
        while ((ev_q.size() != 0 || btn_q.size() != 0) && k < 60000) begin
            @(negedge clk);
            k++;
        end
        if (ev_q.size() != 0) fail_now("busy_timeout");

        // Reset in the middle of an SPI frame and of a one-shot.
        k = 0;
        while (joy_cs_n && k < 1400) begin
            @(negedge clk);
            k++;
        end
        if (joy_cs_n) fail_now("cs_fall_timeout");
        do_write(cyc + 2, n3);
        repeat (300) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_cs_n", joy_cs_n, 1);
        check("midrst_sck", joy_clk, 0);
        check("midrst_readdata", readdata, 8'hF0);
        check("midrst_axis", axis_data, 48'h800800800800);
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        wait_frames(2, 3000);

        check("pending_busy_events", ev_q.size(), 0);
        check("pending_button_events", btn_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
